// File: rtl/unidade_controle_niveis_pkg.sv
// Shared definitions for the level control unit: state codes, debug error code
// and a small max helper used for parameter-derived widths.
package unidade_controle_niveis_pkg;

    typedef enum logic [4:0] {
        INICIAL            = 5'd0,
        PREPARACAO         = 5'd1,
        INIC_NIVEL         = 5'd2,
        JOGANDO            = 5'd3,
        INIC_APAGADO       = 5'd4,
        MOSTRA_APAGADO     = 5'd5,
        INIC_ACESO         = 5'd6,
        MOSTRA_ACESO       = 5'd7,
        PROXIMA_PISCAGEM   = 5'd8,
        FIM_ANIMACAO       = 5'd9,
        CHECA_ULTIMO_NIVEL = 5'd10,
        PROXIMO_NIVEL      = 5'd11,
        EST_GANHOU         = 5'd12,
        PAUSA              = 5'd13,
        EST_PERDEU         = 5'd14
    } estado_t;

    localparam logic [4:0] DB_ERRO = 5'd31;

    function automatic int maxi(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter with synchronous clear, enable and terminal-count flag.
module contador_m #(
    parameter int M = 2,
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera,
    input  logic         conta,
    output logic [W-1:0] Q,
    output logic         fim
);

    assign fim = (Q == W'(M - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            Q <= '0;
        else if (zera)
            Q <= '0;
        else if (conta)
            Q <= fim ? '0 : Q + 1'b1;
    end

endmodule

// File: rtl/unidade_controle_niveis.sv
// Game control FSM: start, per-level play with optional timeout, pause/restart,
// level-complete blink animation, win and lose sequencing.
module unidade_controle_niveis
    import unidade_controle_niveis_pkg::*;
#(
    parameter int N_NIVEIS     = 8,
    parameter int NUM_PISCADAS = 3,
    parameter int T_APAGADO    = 25000000,
    parameter int T_ACESO      = 25000000,
    parameter int T_LIMITE     = 0
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 iniciar,
    input  logic                                 pausar,
    input  logic                                 reiniciar_nivel,
    input  logic                                 nivel_concluido,
    output logic [maxi(1,$clog2(N_NIVEIS))-1:0]  nivel,
    output logic                                 zeraM,
    output logic                                 jogando,
    output logic                                 pausado,
    output logic                                 passou_nivel,
    output logic                                 ganhou,
    output logic                                 perdeu,
    output logic [4:0]                           db_estado
);

    localparam int NW   = maxi(1, $clog2(N_NIVEIS));
    localparam int TMAX = maxi(T_APAGADO, T_ACESO);
    localparam int TW   = maxi(1, $clog2(TMAX + 1));
    localparam int BW   = maxi(1, $clog2(NUM_PISCADAS));
    localparam int LW   = maxi(1, $clog2(T_LIMITE + 1));

    estado_t estado, prox;

    logic [TW-1:0] timer;
    logic [BW-1:0] piscadas;
    logic [LW-1:0] limite;
    logic          fimTimer, fimPiscadas, fimNivel, fimLimite;
    logic          zeraT, contaT, zeraB, contaB, zeraN, contaN, zeraL, contaL;
    logic          fimApagado, fimAceso, timeout;
    logic          unusedBits;

    // Counter controls are Moore decodes of the current state
    always_comb begin
        zeraT  = (estado == PREPARACAO) || (estado == INIC_APAGADO) || (estado == INIC_ACESO);
        contaT = (estado == MOSTRA_APAGADO) || (estado == MOSTRA_ACESO);
        zeraB  = (estado == PREPARACAO) || (estado == FIM_ANIMACAO);
        contaB = (estado == PROXIMA_PISCAGEM);
        zeraN  = (estado == PREPARACAO);
        contaN = (estado == PROXIMO_NIVEL) && !fimNivel;
        zeraL  = (estado == INIC_NIVEL);
        contaL = (estado == JOGANDO);
    end

    contador_m #(.M(TMAX + 1), .W(TW)) uTimer (
        .clock(clock), .reset(reset), .zera(zeraT), .conta(contaT), .Q(timer), .fim(fimTimer)
    );

    contador_m #(.M(NUM_PISCADAS), .W(BW)) uPiscadas (
        .clock(clock), .reset(reset), .zera(zeraB), .conta(contaB), .Q(piscadas), .fim(fimPiscadas)
    );

    contador_m #(.M(N_NIVEIS), .W(NW)) uNivel (
        .clock(clock), .reset(reset), .zera(zeraN), .conta(contaN), .Q(nivel), .fim(fimNivel)
    );

    contador_m #(.M(maxi(T_LIMITE, 1)), .W(LW)) uLimite (
        .clock(clock), .reset(reset), .zera(zeraL), .conta(contaL), .Q(limite), .fim(fimLimite)
    );

    assign fimApagado = (timer == TW'(T_APAGADO - 1));
    assign fimAceso   = (timer == TW'(T_ACESO - 1));
    assign timeout    = (T_LIMITE != 0) && fimLimite;
    assign unusedBits = ^{fimTimer, piscadas, limite};

    always_comb begin
        prox = estado;
        case (estado)
            INICIAL:            if (iniciar) prox = PREPARACAO;
            PREPARACAO:         prox = INIC_NIVEL;
            INIC_NIVEL:         prox = JOGANDO;
            JOGANDO: begin
                if (nivel_concluido)      prox = INIC_APAGADO;
                else if (timeout)         prox = EST_PERDEU;
                else if (reiniciar_nivel) prox = INIC_NIVEL;
                else if (pausar)          prox = PAUSA;
            end
            PAUSA: begin
                if (pausar)               prox = JOGANDO;
                else if (reiniciar_nivel) prox = INIC_NIVEL;
            end
            INIC_APAGADO:       prox = MOSTRA_APAGADO;
            MOSTRA_APAGADO:     if (fimApagado) prox = INIC_ACESO;
            INIC_ACESO:         prox = MOSTRA_ACESO;
            MOSTRA_ACESO:       if (fimAceso) prox = fimPiscadas ? FIM_ANIMACAO : PROXIMA_PISCAGEM;
            PROXIMA_PISCAGEM:   prox = INIC_APAGADO;
            FIM_ANIMACAO:       prox = CHECA_ULTIMO_NIVEL;
            CHECA_ULTIMO_NIVEL: prox = fimNivel ? EST_GANHOU : PROXIMO_NIVEL;
            PROXIMO_NIVEL:      prox = INIC_NIVEL;
            EST_GANHOU:         if (iniciar) prox = PREPARACAO;
            EST_PERDEU:         if (iniciar) prox = PREPARACAO;
            default:            prox = INICIAL;
        endcase
    end

    // Outputs are registered from the next state so they line up with estado
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado       <= INICIAL;
            zeraM        <= 1'b1;
            jogando      <= 1'b0;
            pausado      <= 1'b0;
            passou_nivel <= 1'b0;
            ganhou       <= 1'b0;
            perdeu       <= 1'b0;
        end else begin
            estado       <= prox;
            zeraM        <= (prox == INICIAL) || (prox == PREPARACAO) || (prox == INIC_NIVEL) ||
                            (prox == INIC_APAGADO) || (prox == INIC_ACESO);
            jogando      <= (prox == JOGANDO);
            pausado      <= (prox == PAUSA);
            passou_nivel <= (prox == INIC_ACESO) || (prox == MOSTRA_ACESO) || (prox == EST_GANHOU);
            ganhou       <= (prox == EST_GANHOU);
            perdeu       <= (prox == EST_PERDEU);
        end
    end

    assign db_estado = (estado > EST_PERDEU) ? DB_ERRO : estado;

endmodule

// File: tb/tb_unidade_controle_niveis.sv
// Randomized bench for unidade_controle_niveis against a phase/countdown reference model.
module tb_unidade_controle_niveis;

    localparam int N  = 3;
    localparam int NP = 2;
    localparam int TA = 4;
    localparam int TC = 3;
    localparam int TL = 20;

    logic       clock = 1'b0;
    logic       reset, iniciar, pausar, reiniciar_nivel, nivel_concluido;
    logic [1:0] nivel;
    logic       zeraM, jogando, pausado, passou_nivel, ganhou, perdeu;
    logic [4:0] db_estado;

    int errors = 0;
    int checks = 0;

    // reference model: phase code, level, completed blinks, remaining phase cycles, cycles played
    int m_st, m_lvl, m_blink, m_rem, m_play;

    always #5 clock = ~clock;

    unidade_controle_niveis #(
        .N_NIVEIS(N), .NUM_PISCADAS(NP), .T_APAGADO(TA), .T_ACESO(TC), .T_LIMITE(TL)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .pausar(pausar),
        .reiniciar_nivel(reiniciar_nivel), .nivel_concluido(nivel_concluido),
        .nivel(nivel), .zeraM(zeraM), .jogando(jogando), .pausado(pausado),
        .passou_nivel(passou_nivel), .ganhou(ganhou), .perdeu(perdeu), .db_estado(db_estado)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_lvl = 0; m_blink = 0; m_rem = 0; m_play = 0;
    endtask

    task automatic model_step(input logic ini, input logic pau, input logic rein, input logic conc);
        case (m_st)
            0:  if (ini) m_st = 1;
            1:  begin m_lvl = 0; m_blink = 0; m_st = 2; end
            2:  begin m_play = 0; m_st = 3; end
            3:  begin
                    m_play++;
                    if (conc)                      m_st = 4;
                    else if (TL != 0 && m_play == TL) m_st = 14;
                    else if (rein)                 m_st = 2;
                    else if (pau)                  m_st = 13;
                end
            13: if (pau) m_st = 3; else if (rein) m_st = 2;
            4:  begin m_rem = TA; m_st = 5; end
            5:  begin m_rem--; if (m_rem == 0) m_st = 6; end
            6:  begin m_rem = TC; m_st = 7; end
            7:  begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_blink++;
                        m_st = (m_blink == NP) ? 9 : 8;
                    end
                end
            8:  m_st = 4;
            9:  begin m_blink = 0; m_st = 10; end
            10: m_st = (m_lvl == N - 1) ? 12 : 11;
            11: begin if (m_lvl < N - 1) m_lvl++; m_st = 2; end
            12, 14: if (ini) m_st = 1;
            default: m_st = 0;
        endcase
    endtask

    task automatic compare_all();
        chk("db_estado", int'(db_estado), m_st);
        chk("nivel", int'(nivel), m_lvl);
        chk("zeraM", int'(zeraM), int'(m_st == 0 || m_st == 1 || m_st == 2 || m_st == 4 || m_st == 6));
        chk("jogando", int'(jogando), int'(m_st == 3));
        chk("pausado", int'(pausado), int'(m_st == 13));
        chk("passou_nivel", int'(passou_nivel), int'(m_st == 6 || m_st == 7 || m_st == 12));
        chk("ganhou", int'(ganhou), int'(m_st == 12));
        chk("perdeu", int'(perdeu), int'(m_st == 14));
    endtask

    task automatic ciclo(input logic ini, input logic pau, input logic rein, input logic conc);
        @(negedge clock);
        iniciar = ini; pausar = pau; reiniciar_nivel = rein; nivel_concluido = conc;
        @(posedge clock);
        model_step(ini, pau, rein, conc);
        #1 compare_all();
    endtask

    task automatic rst_async();
        @(negedge clock);
        iniciar = 0; pausar = 0; reiniciar_nivel = 0; nivel_concluido = 0;
        #2 reset = 1'b1;
        #1 model_reset();
        compare_all();
        reset = 1'b0;
    endtask

    int cnt_anim, cnt_pass, cnt_jog;

    initial begin
        reset = 1'b1; iniciar = 0; pausar = 0; reiniciar_nivel = 0; nivel_concluido = 0;
        model_reset();
        #7 compare_all();
        reset = 1'b0;

        // start latency
        ciclo(1, 0, 0, 0);
        ciclo(0, 0, 0, 0);
        ciclo(0, 0, 0, 0);
        chk("lat_jogando", int'(jogando), 1);

        // level 0 completion animation
        ciclo(0, 0, 0, 1);
        cnt_anim = 0; cnt_pass = 0;
        for (int i = 0; i < 60 && db_estado != 5'd9; i++) begin
            if (db_estado >= 5'd4 && db_estado <= 5'd8) cnt_anim++;
            if (passou_nivel) cnt_pass++;
            ciclo(0, 0, 0, 0);
        end
        chk("anim_end", int'(db_estado), 9);
        chk("anim_len", cnt_anim, 19);
        chk("pass_len", cnt_pass, 8);
        repeat (4) ciclo(0, 0, 0, 0);
        chk("nivel_next", int'(nivel), 1);

        // restart level, then let the limit expire
        ciclo(0, 0, 1, 0);
        cnt_jog = 0;
        for (int i = 0; i < 60 && db_estado != 5'd14; i++) begin
            if (jogando) cnt_jog++;
            ciclo(0, 0, 0, 0);
        end
        chk("timeout_len", cnt_jog, 20);
        chk("perdeu_flag", int'(perdeu), 1);

        // completion beats a simultaneous pause
        ciclo(1, 0, 0, 0);
        ciclo(0, 0, 0, 0);
        ciclo(0, 0, 0, 0);
        ciclo(0, 1, 0, 1);
        chk("conc_wins", int'(db_estado), 4);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(999) < 3)
                rst_async();
            else
                ciclo($urandom_range(99) < 30, $urandom_range(99) < 5,
                      $urandom_range(99) < 3,  $urandom_range(99) < 8);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
